pipe_hazard_ctrl: RTL

//  Central stall/flush sequencer for the 5-stage RISC-V pipeline. Drives the hold-enables and bubble/flush inputs of IF/ID, ID/EX, EX/MEM and MEM/WB.

---
 rtl/pipe_ctrl_pkg.sv | 12 +
 rtl/hazard_perf_cnt.sv | 33 +++
 rtl/pipe_hazard_ctrl.sv | 130 +++++++++++++
 3 files changed

// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard sequencer.
package pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1
  } hz_state_e;

  localparam logic [4:0]  REG_X0              = 5'd0;
  localparam int unsigned MEM_TIMEOUT_DEFAULT = 64;

endpackage

// File: rtl/hazard_perf_cnt.sv
// Bank of saturating event counters; each counter advances by one when its inc bit is set.
module hazard_perf_cnt #(
  parameter int unsigned NumCnt = 3,
  parameter int unsigned CNT_W  = 32
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [NumCnt-1:0]             inc,
  output logic [NumCnt-1:0][CNT_W-1:0]  cnt
);

  logic [NumCnt-1:0][CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    for (int i = 0; i < NumCnt; i++) begin
      if (inc[i] && (cnt_q[i] != '1)) begin
        cnt_d[i] = cnt_q[i] + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: memory waits, EX redirects, load-use bubbles.
// Optional perf counters are built when PIPE_HAZARD_CNT_EN is defined; otherwise cnt_* read 0.
module pipe_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = MEM_TIMEOUT_DEFAULT,
  parameter int unsigned CNT_W       = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic             id_use_rs1,
  input  logic             id_use_rs2,
  input  logic [4:0]       ex_rd,
  input  logic             ex_memread,
  input  logic             ex_redirect,
  input  logic             dmem_req,
  input  logic             dmem_ready,
  output logic             pc_en,
  output logic             if_id_en,
  output logic             id_ex_en,
  output logic             ex_mem_en,
  output logic             mem_wb_en,
  output logic             if_id_flush,
  output logic             id_ex_flush,
  output logic             mem_wb_bubble,
  output logic             mem_err,
  output logic [CNT_W-1:0] cnt_lu,
  output logic [CNT_W-1:0] cnt_mw,
  output logic [CNT_W-1:0] cnt_fl
);

  localparam int unsigned      WaitW   = $clog2(MEM_TIMEOUT + 1);
  localparam logic [WaitW-1:0] WaitMax = WaitW'(MEM_TIMEOUT);

  hz_state_e        state_q, state_d;
  logic [WaitW-1:0] wait_cnt_q, wait_cnt_d;
  logic             mem_err_q, mem_err_d;
  logic             mem_done, timeout, load_use;
  logic             do_stall, do_redirect, do_lu;

  always_comb begin
    mem_done = dmem_req && dmem_ready;
    // A timeout counts as a release only if the memory has not answered on that same cycle.
    timeout  = (state_q == MEM_WAIT) && (wait_cnt_q == WaitMax) && !mem_done;
    load_use = ex_memread && (ex_rd != REG_X0) &&
               ((id_use_rs1 && (id_rs1 == ex_rd)) || (id_use_rs2 && (id_rs2 == ex_rd)));

    unique case (state_q)
      MEM_WAIT: do_stall = !mem_done && !timeout;
      default:  do_stall = dmem_req && !dmem_ready;
    endcase

    do_redirect = !do_stall && ex_redirect;
    do_lu       = !do_stall && !ex_redirect && load_use;

    state_d    = do_stall ? MEM_WAIT : RUN;
    wait_cnt_d = '0;
    if (do_stall) begin
      wait_cnt_d = (wait_cnt_q == WaitMax) ? wait_cnt_q : wait_cnt_q + WaitW'(1);
    end
    mem_err_d = mem_err_q || timeout;
  end

  always_comb begin
    pc_en         = 1'b1;
    if_id_en      = 1'b1;
    id_ex_en      = 1'b1;
    ex_mem_en     = 1'b1;
    mem_wb_en     = 1'b1;
    if_id_flush   = 1'b0;
    id_ex_flush   = 1'b0;
    mem_wb_bubble = 1'b0;
    if (reset) begin
      {pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en} = '0;
      {if_id_flush, id_ex_flush, mem_wb_bubble}         = '1;
    end else if (do_stall) begin
      {pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en} = '0;
      mem_wb_bubble = 1'b1;
    end else if (do_redirect) begin
      if_id_flush = 1'b1;
      id_ex_flush = 1'b1;
    end else if (do_lu) begin
      pc_en       = 1'b0;
      if_id_en    = 1'b0;
      id_ex_flush = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= RUN;
      wait_cnt_q <= '0;
      mem_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      mem_err_q  <= mem_err_d;
    end
  end

  assign mem_err = mem_err_q;

`ifdef PIPE_HAZARD_CNT_EN
  logic [2:0]            cnt_inc;
  logic [2:0][CNT_W-1:0] cnt_val;

  assign cnt_inc = {do_redirect, do_stall, do_lu};

  hazard_perf_cnt #(
    .NumCnt (3),
    .CNT_W  (CNT_W)
  ) u_perf_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (cnt_inc),
    .cnt   (cnt_val)
  );

  assign cnt_lu = cnt_val[0];
  assign cnt_mw = cnt_val[1];
  assign cnt_fl = cnt_val[2];
`else
  assign cnt_lu = '0;
  assign cnt_mw = '0;
  assign cnt_fl = '0;
`endif

endmodule
